// File: rtl/trig_pkg.sv
// rtl/trig_pkg.sv - shared types and constants for the trigger configuration parser
package trig_pkg;

    // Parser states, in frame order; DONE/FAIL hold the handshake until activate falls
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MODE = 3'd1,
        ST_LBND = 3'd2,
        ST_UBND = 3'd3,
        ST_HOLD = 3'd4,
        ST_CSUM = 3'd5,
        ST_DONE = 3'd6,
        ST_FAIL = 3'd7
    } trig_state_e;

    // Edge-mode codes carried in mode[1:0]; code 0 behaves like rise
    localparam logic [1:0] EDGE_RISE = 2'd1;
    localparam logic [1:0] EDGE_FALL = 2'd2;
    localparam logic [1:0] EDGE_BOTH = 2'd3;

    localparam int HOLDOFF_W = 16;

    // Mid-scale threshold used as the power-on bound: 2^(w-1) - 1
    function automatic logic [31:0] reset_bound(input int sample_w);
        logic [31:0] one;
        one = 32'd1;
        return (one << (sample_w - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/cfg_le_shift.sv
// rtl/cfg_le_shift.sv - byte-wise LSB-first field assembler with byte counter
module cfg_le_shift #(
    parameter int W  = 8,
    parameter int NB = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [7:0]   data_i,
    output logic [W-1:0] value_o,
    output logic         last_o
);

    localparam int SW = NB * 8;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;

    logic [SW-1:0] sh_q, sh_d, sh_in;
    logic [CW-1:0] cnt_q, cnt_d;

    // New bytes enter at the top and move down, so the first byte ends up in bits [7:0]
    generate
        if (NB == 1) begin : g_one
            assign sh_in = data_i;
        end else begin : g_multi
            assign sh_in = {data_i, sh_q[SW-1:8]};
        end
    endgenerate

    // Bits of the top byte beyond W carry no meaning and are dropped here
    generate
        if (SW > W) begin : g_trim
            logic unused_hi;
            assign unused_hi = ^sh_q[SW-1:W];
        end
    endgenerate

    assign value_o = sh_q[W-1:0];
    assign last_o  = (cnt_q == CW'(NB - 1));

    // Next-state: clear on frame start, shift and count on each accepted byte
    always_comb begin
        sh_d  = sh_q;
        cnt_d = cnt_q;
        if (clr_i) begin
            sh_d  = '0;
            cnt_d = '0;
        end else if (en_i) begin
            sh_d  = sh_in;
            cnt_d = last_o ? '0 : cnt_q + CW'(1);
        end
    end

    // Shadow storage and byte counter registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end else begin
            sh_q  <= sh_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/trig_cfg_parser.sv
// rtl/trig_cfg_parser.sv - framed trigger configuration receiver with validated commit
module trig_cfg_parser
    import trig_pkg::*;
#(
    parameter int CH_COUNT    = 2,
    parameter int SAMPLE_W    = 8,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  activate,
    output logic                                  done,
    output logic                                  err,
    input  logic [7:0]                            rx_data,
    input  logic                                  rx_ready,
    output logic                                  cfg_valid,
    output logic [((CH_COUNT > 1) ? $clog2(CH_COUNT) : 1)-1:0] trig_src,
    output logic                                  en_rise,
    output logic                                  en_fall,
    output logic [SAMPLE_W-1:0]                   lower_bound,
    output logic [SAMPLE_W-1:0]                   upper_bound,
    output logic [HOLDOFF_W-1:0]                  holdoff
);

    localparam int NB    = (SAMPLE_W + 7) / 8;
    localparam int SRC_W = (CH_COUNT > 1) ? $clog2(CH_COUNT) : 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYC);

    localparam logic [TMO_W-1:0]    TMO_RELOAD = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [4:0]          CH_LIM     = 5'(CH_COUNT);
    localparam logic [SAMPLE_W-1:0] RST_BND    = SAMPLE_W'(reset_bound(SAMPLE_W));

    trig_state_e state_q, state_d;

    // Shadow copy of the mode byte; bits [3:2] are not kept
    logic [1:0]           edge_q, edge_d;
    logic [3:0]           chan_q, chan_d;
    logic [7:0]           xor_q, xor_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;

    // Live configuration, only written on commit
    logic [SRC_W-1:0]     src_q, src_d;
    logic                 rise_q, rise_d;
    logic                 fall_q, fall_d;
    logic [SAMPLE_W-1:0]  lower_q, lower_d;
    logic [SAMPLE_W-1:0]  upper_q, upper_d;
    logic [HOLDOFF_W-1:0] hold_q, hold_d;
    logic                 cfg_valid_q, cfg_valid_d;

    logic                 frame_start;
    logic                 lb_en, ub_en, ho_en;
    logic                 lb_last, ub_last, ho_last;
    logic [SAMPLE_W-1:0]  lb_val, ub_val;
    logic [HOLDOFF_W-1:0] ho_val;
    logic                 chk_ok;

    assign frame_start = (state_q == ST_IDLE) && activate;
    assign lb_en       = rx_ready && activate && (state_q == ST_LBND);
    assign ub_en       = rx_ready && activate && (state_q == ST_UBND);
    assign ho_en       = rx_ready && activate && (state_q == ST_HOLD);

    cfg_le_shift #(.W(SAMPLE_W), .NB(NB)) u_lbnd (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (frame_start),
        .en_i   (lb_en),
        .data_i (rx_data),
        .value_o(lb_val),
        .last_o (lb_last)
    );

    cfg_le_shift #(.W(SAMPLE_W), .NB(NB)) u_ubnd (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (frame_start),
        .en_i   (ub_en),
        .data_i (rx_data),
        .value_o(ub_val),
        .last_o (ub_last)
    );

    cfg_le_shift #(.W(HOLDOFF_W), .NB(2)) u_hold (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (frame_start),
        .en_i   (ho_en),
        .data_i (rx_data),
        .value_o(ho_val),
        .last_o (ho_last)
    );

    // Frame is good when the checksum byte cancels the running XOR and the fields are sane
    assign chk_ok = ((xor_q ^ rx_data) == 8'h00)
                 && ({1'b0, chan_q} < CH_LIM)
                 && (lb_val <= ub_val);

    // Frame sequencing, timeout and commit decision
    always_comb begin
        state_d     = state_q;
        edge_d      = edge_q;
        chan_d      = chan_q;
        xor_d       = xor_q;
        tmo_d       = tmo_q;
        src_d       = src_q;
        rise_d      = rise_q;
        fall_d      = fall_q;
        lower_d     = lower_q;
        upper_d     = upper_q;
        hold_d      = hold_q;
        cfg_valid_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (activate) begin
                    state_d = ST_MODE;
                    edge_d  = '0;
                    chan_d  = '0;
                    xor_d   = '0;
                    tmo_d   = TMO_RELOAD;
                end
            end
            ST_MODE, ST_LBND, ST_UBND, ST_HOLD, ST_CSUM: begin
                if (!activate) begin
                    state_d = ST_IDLE;
                end else if (rx_ready) begin
                    xor_d = xor_q ^ rx_data;
                    tmo_d = TMO_RELOAD;
                    unique case (state_q)
                        ST_MODE: begin
                            edge_d  = rx_data[1:0];
                            chan_d  = rx_data[7:4];
                            state_d = ST_LBND;
                        end
                        ST_LBND: if (lb_last) state_d = ST_UBND;
                        ST_UBND: if (ub_last) state_d = ST_HOLD;
                        ST_HOLD: if (ho_last) state_d = ST_CSUM;
                        default: begin
                            if (chk_ok) begin
                                state_d     = ST_DONE;
                                src_d       = chan_q[SRC_W-1:0];
                                rise_d      = (edge_q != EDGE_FALL);
                                fall_d      = (edge_q == EDGE_FALL) || (edge_q == EDGE_BOTH);
                                lower_d     = lb_val;
                                upper_d     = ub_val;
                                hold_d      = ho_val;
                                cfg_valid_d = 1'b1;
                            end else begin
                                state_d = ST_FAIL;
                            end
                        end
                    endcase
                end else if (tmo_q == '0) begin
                    state_d = ST_FAIL;
                end else begin
                    tmo_d = tmo_q - TMO_W'(1);
                end
            end
            default: begin
                if (!activate) state_d = ST_IDLE;
            end
        endcase
    end

    // State, shadow and live configuration registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            edge_q      <= '0;
            chan_q      <= '0;
            xor_q       <= '0;
            tmo_q       <= '0;
            src_q       <= '0;
            rise_q      <= 1'b1;
            fall_q      <= 1'b0;
            lower_q     <= RST_BND;
            upper_q     <= RST_BND;
            hold_q      <= '0;
            cfg_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            edge_q      <= edge_d;
            chan_q      <= chan_d;
            xor_q       <= xor_d;
            tmo_q       <= tmo_d;
            src_q       <= src_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            lower_q     <= lower_d;
            upper_q     <= upper_d;
            hold_q      <= hold_d;
            cfg_valid_q <= cfg_valid_d;
        end
    end

    assign done        = (state_q == ST_DONE) || (state_q == ST_FAIL);
    assign err         = (state_q == ST_FAIL);
    assign cfg_valid   = cfg_valid_q;
    assign trig_src    = src_q;
    assign en_rise     = rise_q;
    assign en_fall     = fall_q;
    assign lower_bound = lower_q;
    assign upper_bound = upper_q;
    assign holdoff     = hold_q;

endmodule

// File: doc/trig_cfg_parser.md
# trig_cfg_parser

Parametrised trigger-configuration receiver. It parses a framed command byte stream from the UART receive path and validates it with a checksum, a channel check and a bounds check. Only validated frames are committed to the trigger registers: edge mode, source channel, hysteresis bounds and holdoff. It sits between the command dispatcher, which drives activate/done, and the trigger comparator, which consumes the outputs. It generalises the single-channel, 8-bit configurator to N channels, wider samples, holdoff and error reporting.

## Interface
- CH_COUNT, 2: number of selectable trigger sources, 1..16.
- SAMPLE_W, 8: bound width in bits, 1..32. NB = ceil(SAMPLE_W/8) bytes per bound.
- TIMEOUT_CYC, 1_000_000: inter-byte timeout in clk cycles, ≥ 2.
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- activate  in  1  dispatcher request. Level, held high until done/err is seen.
- done  out  1  frame finished (commit or reject). Held until activate falls.
- err  out  1  frame rejected. Valid only while done = 1.
- rx_data  in  8  received byte.
- rx_ready  in  1  one-cycle strobe, rx_data valid.
- cfg_valid  out  1  one-cycle pulse on commit.
- trig_src  out  max(1,$clog2(CH_COUNT))  selected channel.
- en_rise, en_fall  out  1 each  edge enables.
- lower_bound, upper_bound  out  SAMPLE_W  hysteresis thresholds.
- holdoff  out  16  samples ignored after a trigger fires.

## Operation
- Frame format, bytes in order; multi-byte fields are LSB first:
  - mode: [1:0] edge (1 = rise, 2 = fall, 3 = both, 0 = rise); [3:2] ignored; [7:4] channel.
  - NB bytes lower bound.
  - NB bytes upper bound.
  - 2 bytes holdoff.
  - 1 checksum byte = XOR of all preceding frame bytes.
- Bits of the top bound byte above SAMPLE_W are ignored.
- States:
  - IDLE: activate → MODE. Clears shadow registers, running XOR and byte counter.
  - MODE → LBND → UBND → HOLD → CSUM. Each transition happens on rx_ready. LBND, UBND and HOLD use a byte counter.
  - CSUM: on rx_ready, commit if all three checks pass, then go to DONE. Otherwise go to FAIL. Checks:
    - checksum matches;
    - channel < CH_COUNT;
    - lower ≤ upper (unsigned).
  - DONE: done = 1, err = 0. FAIL: done = 1, err = 1. Both return to IDLE when activate = 0.
- Received bytes go to shadow registers. Live outputs change only on commit, all fields atomically.
- Timeout counter reloads on entry to MODE and on every accepted byte. On expiry in MODE..CSUM → FAIL.
- activate low in MODE..CSUM → IDLE immediately. No commit, no done.
- rx_ready in IDLE, DONE or FAIL is ignored.
- Reset values:
  - en_rise = 1, en_fall = 0, trig_src = 0, holdoff = 0;
  - lower_bound = upper_bound = 2^(SAMPLE_W-1) − 1 (127 at SAMPLE_W = 8);
  - done = err = cfg_valid = 0; state IDLE.
- Reset has priority over everything, including mid-frame. Configuration reverts to reset values.

## Timing
- activate sampled high in IDLE → MODE on the next edge. The first byte is accepted from the following cycle.
- Checksum rx_ready in cycle N → in cycle N+1:
  - on commit, outputs updated, cfg_valid = 1 and done = 1;
  - on reject, done = 1 and err = 1, outputs unchanged.
- activate low in cycle M while in DONE/FAIL → done = err = 0 in cycle M+1.
- Back-to-back rx_ready on consecutive cycles must be accepted.
- Timeout: FAIL is entered exactly TIMEOUT_CYC cycles after the last reload if no byte arrives. A byte arriving in the expiry cycle wins.

## Structure
- trig_pkg holds:
  - state enum;
  - edge-mode codes (EDGE_RISE = 1, EDGE_FALL = 2, EDGE_BOTH = 3);
  - HOLDOFF_W = 16;
  - a function returning the reset bound for a given SAMPLE_W.
- One sub-module, cfg_le_shift: a byte-wise LSB-first shift assembler with byte counter. It is instantiated for each bound and for holdoff, or shared with a field select.

## Test plan
- Defaults: CH_COUNT = 2, SAMPLE_W = 8. Reset, then read outputs → en_rise = 1, en_fall = 0, bounds = 127/127, holdoff = 0, trig_src = 0, done = 0.
- Valid frame 13 40 C0 10 00 83 → trig_src = 1, rise = fall = 1, lower = 0x40, upper = 0xC0, holdoff = 16. cfg_valid pulses once; done = 1, err = 0 one cycle after the last byte.
- Same frame with checksum 84 → err = 1, all outputs keep their previous values, no cfg_valid. Frame 02 C0 40 00 00 82 (lower > upper) → err = 1. Frame 23 … (channel 2 ≥ CH_COUNT) → err = 1.
- TIMEOUT_CYC = 100: send byte 01, then idle for 100 cycles → FAIL (err = 1). Repeat with a byte at cycle 99 → no error.
- Abort: activate drops after 2 bytes → IDLE, done stays 0, outputs unchanged. rst low mid-frame → reset values, IDLE.
- SAMPLE_W = 12: frame 00 34 F2 FF 0F 00 00 + checksum → lower = 0x234, upper = 0xFFF; mode 0 → rise only. Back-to-back rx_ready for the whole frame → accepted.
